// File: rtl/seg7_scroll_ctrl_pkg.sv
// Shared definitions for the 7-segment scroll sequencer: blank symbol code,
// FSM state encoding and the default message length.
package seg7_pkg;

  localparam logic [3:0] BLANK_CODE      = 4'd15;
  localparam int         DEFAULT_MSG_LEN = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

endpackage

// File: rtl/seg7_scroll_ctrl_if.sv
// Control/display bundle between the user controls, the scroll sequencer and
// the seg7 decoder. The sequencer takes the slave side.
interface seg7_scroll_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  logic                  start;
  logic                  stop;
  logic [3:0]            digit;
  logic [NUM_DIGITS-1:0] an;
  logic [3:0]            pos;
  logic                  busy;

  modport master (output start, stop, input digit, an, pos, busy);
  modport slave  (input start, stop, output digit, an, pos, busy);
endinterface

// File: rtl/seg7_scroll_ctrl_tick_div.sv
// Free-running prescaler: counts 0..DIV-1 while enabled and pulses tick for the
// single cycle spent at the terminal count. clr forces the count back to 0.
module tick_div #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int W = $clog2(DIV);

  logic [W-1:0] r_cnt;

  assign tick = en && !clr && (r_cnt == W'(DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= tick ? '0 : r_cnt + W'(1);
    end
  end
endmodule

// File: rtl/seg7_scroll_ctrl.sv
// Scroll/multiplex sequencer feeding the seg7 decoder. Define SCROLL_GAP_EN to
// insert one blank symbol between message repetitions (L = MSG_LEN+1).
module seg7_scroll_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int MSG_LEN    = DEFAULT_MSG_LEN,
  parameter int SCROLL_DIV = 12_000_000,
  parameter int MUX_DIV    = 12_000
) (
  input logic               clk,
  input logic               rst,
  seg7_scroll_ctrl_if.slave bus
);
`ifdef SCROLL_GAP_EN
  localparam int L = MSG_LEN + 1;
`else
  localparam int L = MSG_LEN;
`endif
  localparam int SW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  state_t                r_state;
  state_t                w_state_next;
  logic                  w_clr;
  logic                  w_scroll_en;
  logic                  w_mux_en;
  logic                  w_scroll_tick;
  logic                  w_mux_tick;
  logic [3:0]            r_pos;
  logic [SW-1:0]         r_slot;
  logic [4:0]            w_sum;
  logic [4:0]            w_sym;
  logic [3:0]            w_digit;
  logic [NUM_DIGITS-1:0] w_an;
  logic [3:0]            r_digit;
  logic [NUM_DIGITS-1:0] r_an;
  logic                  r_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // stop outranks start everywhere; in IDLE the start+stop pair does nothing
  always_comb begin
    w_state_next = r_state;
    w_clr        = 1'b0;
    w_scroll_en  = (r_state == RUN);
    w_mux_en     = (r_state == RUN) || (r_state == PAUSE);
    case (r_state)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          w_state_next = RUN;
          w_clr        = 1'b1;
        end
      end
      RUN: begin
        if (bus.stop) w_state_next = PAUSE;
      end
      PAUSE: begin
        if (bus.stop)       w_state_next = IDLE;
        else if (bus.start) w_state_next = RUN;
      end
      default: w_state_next = IDLE;
    endcase
  end

  tick_div #(.DIV(SCROLL_DIV)) u_scroll_div (
    .clk  (clk),
    .rst  (rst),
    .en   (w_scroll_en),
    .clr  (w_clr),
    .tick (w_scroll_tick)
  );

  tick_div #(.DIV(MUX_DIV)) u_mux_div (
    .clk  (clk),
    .rst  (rst),
    .en   (w_mux_en),
    .clr  (w_clr),
    .tick (w_mux_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pos  <= '0;
      r_slot <= '0;
    end else if (w_clr) begin
      r_pos  <= '0;
      r_slot <= '0;
    end else begin
      if (w_scroll_tick) r_pos  <= (r_pos == 4'(L - 1)) ? '0 : r_pos + 4'd1;
      if (w_mux_tick)    r_slot <= (r_slot == SW'(NUM_DIGITS - 1)) ? '0 : r_slot + SW'(1);
    end
  end

  // slot < NUM_DIGITS <= L, so one conditional subtract replaces a modulo
  assign w_sum   = {1'b0, r_pos} + 5'(r_slot);
  assign w_sym   = (w_sum >= 5'(L)) ? w_sum - 5'(L) : w_sum;
  assign w_digit = (w_sym == 5'(MSG_LEN)) ? BLANK_CODE : w_sym[3:0];

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_an
    assign w_an[gi] = (r_slot == SW'(gi));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_digit <= BLANK_CODE;
      r_an    <= '0;
      r_busy  <= 1'b0;
    end else if (r_state == IDLE) begin
      r_digit <= BLANK_CODE;
      r_an    <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_digit <= w_digit;
      r_an    <= w_an;
      r_busy  <= 1'b1;
    end
  end

  assign bus.digit = r_digit;
  assign bus.an    = r_an;
  assign bus.pos   = r_pos;
  assign bus.busy  = r_busy;

endmodule

// File: tb/tb_seg7_scroll_ctrl.sv
// Directed bench for seg7_scroll_ctrl (NUM_DIGITS=4, MSG_LEN=7, SCROLL_DIV=8,
// MUX_DIV=2); expectations follow SCROLL_GAP_EN when it is defined.
module tb_seg7_scroll_ctrl;
  localparam int ND = 4;

`ifdef SCROLL_GAP_EN
  int exp_syms [4] = '{5, 6, 15, 0};
  int exp_pos56    = 7;
  int exp_pos64    = 0;
`else
  int exp_syms [4] = '{5, 6, 0, 1};
  int exp_pos56    = 0;
  int exp_pos64    = 1;
`endif

  // k = 1..16 after the start edge
  int exp_an  [16] = '{1, 1, 2, 2, 4, 4, 8, 8, 1, 1, 2, 2, 4, 4, 8, 8};
  int exp_dig [16] = '{0, 0, 1, 1, 2, 2, 3, 3, 1, 1, 2, 2, 3, 3, 4, 4};
  int exp_pos [16] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 2};

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   k;
  int   n_total = 0;
  int   n_pass  = 0;

  always #5 clk = ~clk;

  seg7_scroll_ctrl_if #(.NUM_DIGITS(ND)) bus ();

  seg7_scroll_ctrl #(
    .NUM_DIGITS (ND),
    .MSG_LEN    (7),
    .SCROLL_DIV (8),
    .MUX_DIV    (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s k=%0d: got %0d, expected %0d", tag, k, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      k++;
    end
    #1;
  endtask

  task automatic step_to(input int target);
    step(target - k);
  endtask

  initial begin
    k = 0;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    $display("idle: 20 cycles after reset");
    for (int i = 0; i < 20; i++) begin
      step(1);
      check("idle_an", bus.an, 0);
      check("idle_digit", bus.digit, 15);
      check("idle_busy", bus.busy, 0);
    end

    $display("run: start pulse, first 16 cycles");
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    k = 0;
    check("busy_lag", bus.busy, 0);
    for (int i = 0; i < 16; i++) begin
      step(1);
      check("run_an", bus.an, exp_an[i]);
      check("run_digit", bus.digit, exp_dig[i]);
      check("run_pos", bus.pos, exp_pos[i]);
      check("run_busy", bus.busy, 1);
    end

    $display("wrap: frame at pos 5 and pos wrap");
    step_to(41);
    for (int j = 0; j < 4; j++) begin
      check("pos5_an", bus.an, 32'(1 << j));
      check("pos5_digit", bus.digit, exp_syms[j]);
      step(2);
    end
    step_to(55);
    check("pos_before_wrap", bus.pos, 6);
    step(1);
    check("pos_k56", bus.pos, exp_pos56);
    step_to(64);
    check("pos_k64", bus.pos, exp_pos64);

    $display("reset asserted mid-run");
    rst = 1'b1;
    #2;
    check("rst_an", bus.an, 0);
    check("rst_digit", bus.digit, 15);
    check("rst_busy", bus.busy, 0);
    check("rst_pos", bus.pos, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("pause at pos 3, resume");
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    k = 0;
    step_to(26);
    bus.stop = 1'b1;
    step(1);
    bus.stop = 1'b0;
    check("pause_pos", bus.pos, 3);
    step(1);
    check("pause_an_k28", bus.an, 2);
    check("pause_digit_k28", bus.digit, 4);
    check("pause_busy", bus.busy, 1);
    step_to(30);
    check("pause_an_k30", bus.an, 4);
    check("pause_digit_k30", bus.digit, 5);
    step_to(35);
    check("pause_frozen_pos", bus.pos, 3);
    step_to(64);
    check("pause_an_k64", bus.an, 8);
    check("pause_digit_k64", bus.digit, 6);
    step_to(66);
    check("pause_an_k66", bus.an, 1);
    check("pause_digit_k66", bus.digit, 3);
    step_to(67);
    check("pause_pos_end", bus.pos, 3);
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    step_to(72);
    check("resume_pos_hold", bus.pos, 3);
    step(1);
    check("resume_pos_inc", bus.pos, 4);

    $display("start+stop in RUN, then stop to IDLE");
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    step(1);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    step(1);
    check("both_busy", bus.busy, 1);
    step_to(84);
    check("both_paused_pos", bus.pos, 4);
    bus.stop = 1'b1;
    step(1);
    bus.stop = 1'b0;
    step(1);
    check("stop_idle_an", bus.an, 0);
    check("stop_idle_busy", bus.busy, 0);
    check("stop_idle_digit", bus.digit, 15);

    $display("start+stop in IDLE ignored");
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    step(3);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    check("idle_pair_busy", bus.busy, 0);
    check("idle_pair_an", bus.an, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/seg7_scroll_ctrl.md
# seg7_scroll_ctrl

Sequencer for the 7-segment letter decoder. Steps a message index through the decoder's symbol codes so the message scrolls across a row of time-multiplexed 7-segment digits, and drives the one-hot digit select lines. Sits between the top-level user controls (start/stop) and the `seg7` decoder. It owns all display timing.

## Interface
- `NUM_DIGITS`, default 4: number of physical digits; 1 ≤ NUM_DIGITS ≤ MSG_LEN.
- `MSG_LEN`, default 7: number of message symbols; valid codes are 0..MSG_LEN-1.
- `SCROLL_DIV`, default 12_000_000: clk cycles per scroll step; ≥ 2.
- `MUX_DIV`, default 12_000: clk cycles per digit slot; ≥ 2.
- `clk` input, 1 bit: single clock; all state on rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `start` input, 1 bit: level sampled each cycle; 1 = start or resume.
- `stop` input, 1 bit: level sampled each cycle; 1 = pause, or stop when already paused.
- `digit` output, 4 bits: symbol code to the `seg7` decoder; BLANK_CODE = 4'd15.
- `an` output, NUM_DIGITS bits: one-hot digit enable, active-high; bit k = slot k (leftmost = 0).
- `pos` output, 4 bits: current scroll position, 0..L-1.
- `busy` output, 1 bit: 1 in RUN or PAUSE.

## Operation
- L = MSG_LEN, or MSG_LEN+1 when the gap feature is enabled (see Configuration).
- FSM states: IDLE, RUN, PAUSE. Reset state is IDLE.
- IDLE: `start`=1 moves to RUN and clears pos, slot and both prescalers to 0.
- RUN: `stop`=1 moves to PAUSE.
- PAUSE: `stop`=1 moves to IDLE. Otherwise `start`=1 moves to RUN and resumes from the current pos and scroll prescaler value.
- Simultaneous `start`&`stop`: `stop` wins in every state. In IDLE the pair is ignored.
- Scroll prescaler counts 0..SCROLL_DIV-1, in RUN only. Its terminal count sets pos ← (pos+1 == L) ? 0 : pos+1.
- Mux prescaler counts 0..MUX_DIV-1, in RUN and PAUSE. Its terminal count sets slot ← (slot+1 == NUM_DIGITS) ? 0 : slot+1.
- Symbol index: s = pos + slot. If s ≥ L, subtract L once (no divider is needed, since slot < NUM_DIGITS ≤ L). Width is 5 bits internally.
- `digit` = s in RUN/PAUSE, except s == MSG_LEN (gap symbol), which gives BLANK_CODE. In IDLE `digit` = BLANK_CODE.
- `an` = 1<<slot in RUN/PAUSE, and 0 in IDLE.
- Reset values: state IDLE, pos 0, slot 0, both prescalers 0, `digit` 4'd15, `an` 0, `busy` 0. Asserting reset mid-scroll returns all outputs to these values immediately (asynchronous).

## Timing
- `digit`, `an` and `busy` are registered. They reflect the state/pos/slot one cycle after those registers change.
- After `start` is sampled in IDLE at edge E: state is RUN at E. `busy`=1, `an`=1, `digit`=0 from E+1.
- First pos increment happens at edge E+SCROLL_DIV, then every SCROLL_DIV cycles.
- slot advances every MUX_DIV cycles. `an` and `digit` change together at the same edge. There is no glitch cycle with two enables set.
- pos wrap and slot wrap on the same edge: both apply, and the output on the next cycle uses both new values.
- PAUSE freezes pos and the scroll prescaler. Multiplexing continues, so the frozen frame stays visible.

## Configuration
- `SCROLL_GAP_EN` defined: L = MSG_LEN+1. The index MSG_LEN displays BLANK_CODE, which gives one blank symbol between message repetitions.
- `SCROLL_GAP_EN` undefined: L = MSG_LEN. The message wraps seamlessly and BLANK_CODE appears only in IDLE.

## Structure
- `seg7_pkg` holds BLANK_CODE (4'd15), the state enum {IDLE, RUN, PAUSE}, and the default MSG_LEN.
- Sub-module `tick_div` (parameter DIV, inputs `clk`/`rst`/`en`/`clr`, output one-cycle `tick`) is instantiated twice: once for the scroll prescaler and once for the mux prescaler.
- `seg7` is not instantiated inside this block. The top level connects `digit` to it.

## Test plan
All scenarios use NUM_DIGITS=4, MSG_LEN=7, SCROLL_DIV=8, MUX_DIV=2.
- Reset, then idle for 20 cycles → `an`=0, `digit`=15, `busy`=0 throughout.
- One-cycle `start` pulse → `an` cycles 0001, 0010, 0100, 1000 every 2 cycles with `digit` 0, 1, 2, 3. After 8 cycles pos=1 and `digit` shows 1, 2, 3, 4.
- Run 56 cycles without the gap feature → pos goes 0..6 then back to 0. At pos=5, slots show 5, 6, 0, 1.
- Run with `SCROLL_GAP_EN` defined → L=8. At pos=5, slots show 5, 6, 15, 0. pos reaches 7 before wrapping.
- `stop` during RUN at pos=3, wait 40 cycles, then `start` → pos stays 3 and `an` keeps rotating while paused. The next pos increment comes after the remaining prescaler count.
- `start`&`stop` together in RUN → PAUSE. A second `stop` → IDLE with `an`=0. Reset asserted mid-RUN → outputs at reset values in the same cycle.
